// File: rtl/fft_frame_ctrl_if.sv
// Streaming bundle around fft_frame_ctrl: the sample input, the first-stage drive
// and the en/cnt pair returned by the last pipeline stage.
interface fft_frame_ctrl_if #(
  parameter int width = 16,
  parameter int N     = 9
);
  logic                    s_valid;
  logic                    s_ready;
  logic signed [width-1:0] s_re;
  logic signed [width-1:0] s_im;

  logic                    pipe_en;
  logic [N-1:0]            pipe_cnt;
  logic signed [width-1:0] pipe_re;
  logic signed [width-1:0] pipe_im;

  logic                    ret_en;
  logic [N-1:0]            ret_cnt;

  modport slave (
    input  s_valid, s_re, s_im, ret_en, ret_cnt,
    output s_ready, pipe_en, pipe_cnt, pipe_re, pipe_im
  );

  modport master (
    output s_valid, s_re, s_im, ret_en, ret_cnt,
    input  s_ready, pipe_en, pipe_cnt, pipe_re, pipe_im
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame controller for a streaming FFT: loads 2^N samples per frame into the first stage and
// tracks frames in flight. Optional frame_cnt output is enabled by FFT_FRAME_CTRL_FRAME_CNT_EN.
module fft_frame_ctrl #(
  parameter int width = 16,
  parameter int N     = 9,
  parameter int CONT  = 0
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            start,
  fft_frame_ctrl_if.slave bus,
  output logic            busy,
  output logic            frame_done,
  output logic            underrun
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]     frame_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [N-1:0]     CNT_MAX   = {N{1'b1}};
  localparam logic [N-1:0]     CNT_ZERO  = {N{1'b0}};
  localparam logic [N-1:0]     CNT_ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] SAMP_ZERO = {width{1'b0}};
  localparam logic [3:0]       OUTST_MAX = 4'd15;
  localparam logic             CONT_ON   = (CONT != 32'sd0);

  // Saturating up/down update of the frames-in-flight counter.
  function automatic logic [3:0] outst_update(input logic [3:0] cur,
                                              input logic       inc,
                                              input logic       dec);
    logic [3:0] res;
    case ({inc, dec})
      2'b10:   res = (cur == OUTST_MAX) ? cur : cur + 4'd1;
      2'b01:   res = (cur == 4'd0) ? cur : cur - 4'd1;
      default: res = cur;
    endcase
    return res;
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [N-1:0]            load_cnt_r;
  logic [3:0]              outst_cnt_r;
  logic [3:0]              outst_nxt_s;
  logic                    go_s;
  logic                    last_load_s;
  logic                    done_evt_s;
  logic                    underrun_nxt_s;
  logic                    pipe_en_nxt_s;
  logic [N-1:0]            pipe_cnt_nxt_s;
  logic signed [width-1:0] pipe_re_nxt_s;
  logic signed [width-1:0] pipe_im_nxt_s;

  logic                    s_ready_r;
  logic                    pipe_en_r;
  logic [N-1:0]            pipe_cnt_r;
  logic signed [width-1:0] pipe_re_r;
  logic signed [width-1:0] pipe_im_r;
  logic                    busy_r;
  logic                    frame_done_r;
  logic                    underrun_r;

  assign go_s        = start | CONT_ON;
  assign last_load_s = (state_r == ST_LOAD) && (load_cnt_r == CNT_MAX);
  assign done_evt_s  = bus.ret_en && (bus.ret_cnt == CNT_MAX);
  // The counter moves on the same edge that raises frame_done, so busy drops one cycle later.
  assign outst_nxt_s = outst_update(outst_cnt_r, last_load_s, done_evt_s);

  // Next-state logic for the IDLE/LOAD/DRAIN sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (last_load_s && !go_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if ((outst_cnt_r == 4'd0) && !last_load_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // First-stage drive: a missing sample becomes a zero so the frame keeps its length.
  always_comb begin
    pipe_en_nxt_s  = 1'b0;
    pipe_cnt_nxt_s = CNT_ZERO;
    pipe_re_nxt_s  = SAMP_ZERO;
    pipe_im_nxt_s  = SAMP_ZERO;
    if (state_r == ST_LOAD) begin
      pipe_en_nxt_s  = 1'b1;
      pipe_cnt_nxt_s = load_cnt_r;
      if (bus.s_valid) begin
        pipe_re_nxt_s = bus.s_re;
        pipe_im_nxt_s = bus.s_im;
      end else begin
        pipe_re_nxt_s = SAMP_ZERO;
        pipe_im_nxt_s = SAMP_ZERO;
      end
    end else begin
      pipe_en_nxt_s  = 1'b0;
      pipe_cnt_nxt_s = CNT_ZERO;
    end
  end

  // Underrun is sticky across back-to-back frames and cleared only by a fresh start from IDLE.
  always_comb begin
    underrun_nxt_s = underrun_r;
    if ((state_r == ST_IDLE) && (state_nxt_s == ST_LOAD)) begin
      underrun_nxt_s = 1'b0;
    end else if ((state_r == ST_LOAD) && !bus.s_valid) begin
      underrun_nxt_s = 1'b1;
    end else begin
      underrun_nxt_s = underrun_r;
    end
  end

  // State, load counter and frames-in-flight registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_r     <= ST_IDLE;
      load_cnt_r  <= CNT_ZERO;
      outst_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      outst_cnt_r <= outst_nxt_s;
      if (state_r == ST_LOAD) begin
        load_cnt_r <= load_cnt_r + CNT_ONE;
      end else begin
        load_cnt_r <= CNT_ZERO;
      end
    end
  end

  // Registered outputs, derived from next-cycle values so they line up with the state.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      s_ready_r    <= 1'b0;
      pipe_en_r    <= 1'b0;
      pipe_cnt_r   <= CNT_ZERO;
      pipe_re_r    <= SAMP_ZERO;
      pipe_im_r    <= SAMP_ZERO;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      s_ready_r    <= (state_nxt_s == ST_LOAD);
      pipe_en_r    <= pipe_en_nxt_s;
      pipe_cnt_r   <= pipe_cnt_nxt_s;
      pipe_re_r    <= pipe_re_nxt_s;
      pipe_im_r    <= pipe_im_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE) || (outst_nxt_s != 4'd0);
      frame_done_r <= done_evt_s;
      underrun_r   <= underrun_nxt_s;
    end
  end

  assign bus.s_ready  = s_ready_r;
  assign bus.pipe_en  = pipe_en_r;
  assign bus.pipe_cnt = pipe_cnt_r;
  assign bus.pipe_re  = pipe_re_r;
  assign bus.pipe_im  = pipe_im_r;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign underrun     = underrun_r;

`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Completed-frame counter, wrapping at 16 bits.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      frame_cnt_r <= 16'd0;
    end else if (done_evt_s) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl (N=9): single frame, back-to-back, underrun,
// mid-frame reset, frame_done in IDLE and a last-load/frame_done collision.
module tb_fft_frame_ctrl;
  localparam int W    = 16;
  localparam int NB   = 9;
  localparam int LAST = (1 << NB) - 1;

  logic clk;
  logic areset;
  logic start;
  logic busy;
  logic frame_done;
  logic underrun;
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  int tests;
  int fails;

  fft_frame_ctrl_if #(.width(W), .N(NB)) bus_if ();

  fft_frame_ctrl #(.width(W), .N(NB), .CONT(0)) dut (
    .clk        (clk),
    .areset     (areset),
    .start      (start),
    .bus        (bus_if.slave),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic signed [W-1:0] exp_re(input int k);
    return W'(k * 3 - 700);
  endfunction

  function automatic logic signed [W-1:0] exp_im(input int k);
    return W'(1000 - k * 5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v);
    bus_if.s_valid = v;
    bus_if.s_re    = exp_re(k);
    bus_if.s_im    = exp_im(k);
  endtask

  task automatic test_reset();
    areset = 1'b0; start = 1'b0;
    bus_if.s_valid = 1'b0; bus_if.s_re = '0; bus_if.s_im = '0;
    bus_if.ret_en = 1'b0; bus_if.ret_cnt = '0;
    #2;
    tests++;
    if ({bus_if.s_ready, bus_if.pipe_en, busy, frame_done, underrun} !== 5'b0 ||
        bus_if.pipe_cnt !== '0 || bus_if.pipe_re !== '0 || bus_if.pipe_im !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdy/en/busy/done/und=%b%b%b%b%b cnt=%0d, want all 0",
               bus_if.s_ready, bus_if.pipe_en, busy, frame_done, underrun, bus_if.pipe_cnt);
    end
    start = 1'b1;
    tick(); tick();
    tests++;
    if (bus_if.s_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: s_ready=%b busy=%b, want 0 0", bus_if.s_ready, busy);
    end
    start = 1'b0;
    areset = 1'b1;
    tick(); tick();
    tests++;
    if (bus_if.s_ready !== 1'b0 || busy !== 1'b0 || bus_if.pipe_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: s_ready=%b busy=%b pipe_en=%b, want 0 0 0",
               bus_if.s_ready, busy, bus_if.pipe_en);
    end
  endtask

  task automatic test_single_frame();
    start = 1'b1; tick(); start = 1'b0;
    tests++;
    if (bus_if.s_ready !== 1'b1 || busy !== 1'b1 || bus_if.pipe_en !== 1'b0) begin
      fails++;
      $display("FAIL single_enter: s_ready=%b busy=%b pipe_en=%b, want 1 1 0",
               bus_if.s_ready, busy, bus_if.pipe_en);
    end
    for (int k = 0; k <= LAST; k++) begin
      drive(k, 1'b1); tick();
      tests++;
      if (bus_if.pipe_en !== 1'b1 || bus_if.pipe_cnt !== NB'(k) || bus_if.pipe_re !== exp_re(k) ||
          bus_if.pipe_im !== exp_im(k) || bus_if.s_ready !== (k != LAST)) begin
        fails++;
        $display("FAIL single_load k=%0d: en=%b cnt=%0d re=%0d im=%0d rdy=%b, want 1 %0d %0d %0d %b",
                 k, bus_if.pipe_en, bus_if.pipe_cnt, bus_if.pipe_re, bus_if.pipe_im, bus_if.s_ready,
                 k, exp_re(k), exp_im(k), (k != LAST));
      end
    end
    bus_if.s_valid = 1'b0;
    tick();
    tests++;
    if (bus_if.pipe_en !== 1'b0 || bus_if.pipe_cnt !== '0 || bus_if.pipe_re !== '0 ||
        bus_if.s_ready !== 1'b0 || busy !== 1'b1 || underrun !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: en=%b cnt=%0d re=%0d rdy=%b busy=%b und=%b, want 0 0 0 0 1 0",
               bus_if.pipe_en, bus_if.pipe_cnt, bus_if.pipe_re, bus_if.s_ready, busy, underrun);
    end
    bus_if.ret_en = 1'b1; bus_if.ret_cnt = NB'(LAST - 1);
    tick(); bus_if.ret_en = 1'b0;
    tests++;
    if (frame_done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_ret_510: frame_done=%b busy=%b, want 0 1", frame_done, busy);
    end
    bus_if.ret_en = 1'b1; bus_if.ret_cnt = NB'(LAST);
    tick(); bus_if.ret_en = 1'b0;
    tests++;
    if (frame_done !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_done: frame_done=%b busy=%b, want 1 1", frame_done, busy);
    end
    tick();
    tests++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || bus_if.s_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: frame_done=%b busy=%b s_ready=%b, want 0 0 0",
               frame_done, busy, bus_if.s_ready);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; tick(); start = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k <= LAST; k++) begin
        start = (f == 0) && (k == LAST);
        drive(k, 1'b1); tick();
        tests++;
        if (bus_if.pipe_en !== 1'b1 || bus_if.pipe_cnt !== NB'(k) || bus_if.pipe_re !== exp_re(k) ||
            bus_if.s_ready !== ((f == 0) || (k != LAST))) begin
          fails++;
          $display("FAIL b2b_load f=%0d k=%0d: en=%b cnt=%0d re=%0d rdy=%b, want 1 %0d %0d %b",
                   f, k, bus_if.pipe_en, bus_if.pipe_cnt, bus_if.pipe_re, bus_if.s_ready,
                   k, exp_re(k), ((f == 0) || (k != LAST)));
        end
      end
      start = 1'b0;
      tests++;
      if (dut.outst_cnt_r !== 4'(f + 1)) begin
        fails++;
        $display("FAIL b2b_outstanding f=%0d: got %0d, want %0d", f, dut.outst_cnt_r, f + 1);
      end
    end
    bus_if.s_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tests++;
    if (bus_if.s_ready !== 1'b0 || bus_if.pipe_en !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_drain_start: s_ready=%b pipe_en=%b busy=%b, want 0 0 1",
               bus_if.s_ready, bus_if.pipe_en, busy);
    end
    for (int d = 1; d >= 0; d--) begin
      bus_if.ret_en = 1'b1; bus_if.ret_cnt = NB'(LAST);
      tick(); bus_if.ret_en = 1'b0;
      tests++;
      if (frame_done !== 1'b1 || dut.outst_cnt_r !== 4'(d)) begin
        fails++;
        $display("FAIL b2b_done d=%0d: frame_done=%b outstanding=%0d, want 1 %0d",
                 d, frame_done, dut.outst_cnt_r, d);
      end
      tick();
      tests++;
      if (frame_done !== 1'b0 || busy !== (d != 0) || bus_if.s_ready !== 1'b0) begin
        fails++;
        $display("FAIL b2b_after_done d=%0d: frame_done=%b busy=%b s_ready=%b, want 0 %b 0",
                 d, frame_done, busy, bus_if.s_ready, (d != 0));
      end
    end
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
    tests++;
    if (frame_cnt !== 16'd3) begin
      fails++;
      $display("FAIL frame_cnt_three: got %0d, want 3", frame_cnt);
    end
`endif
  endtask

  task automatic test_underrun();
    logic v;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k <= LAST; k++) begin
      v = !((k >= 100) && (k <= 102));
      drive(k, v); tick();
      tests++;
      if (bus_if.pipe_cnt !== NB'(k) || bus_if.pipe_re !== (v ? exp_re(k) : W'(0)) ||
          bus_if.pipe_im !== (v ? exp_im(k) : W'(0)) || underrun !== (k >= 100)) begin
        fails++;
        $display("FAIL underrun_load k=%0d: cnt=%0d re=%0d im=%0d und=%b, want %0d %0d %0d %b",
                 k, bus_if.pipe_cnt, bus_if.pipe_re, bus_if.pipe_im, underrun, k,
                 (v ? exp_re(k) : W'(0)), (v ? exp_im(k) : W'(0)), (k >= 100));
      end
    end
    bus_if.s_valid = 1'b0;
    bus_if.ret_en = 1'b1; bus_if.ret_cnt = NB'(LAST);
    tick(); bus_if.ret_en = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_sticky: busy=%b underrun=%b, want 0 1", busy, underrun);
    end
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; tick(); start = 1'b0;
    tests++;
    if (underrun !== 1'b0 || bus_if.s_ready !== 1'b1) begin
      fails++;
      $display("FAIL restart_clears_underrun: underrun=%b s_ready=%b, want 0 1", underrun, bus_if.s_ready);
    end
    for (int k = 0; k <= 300; k++) begin
      drive(k, 1'b1); tick();
    end
    tests++;
    if (bus_if.pipe_cnt !== NB'(300) || bus_if.pipe_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_load_reach: cnt=%0d en=%b, want 300 1", bus_if.pipe_cnt, bus_if.pipe_en);
    end
    #1 areset = 1'b0;
    #1;
    tests++;
    if ({bus_if.s_ready, bus_if.pipe_en, busy, frame_done, underrun} !== 5'b0 ||
        bus_if.pipe_cnt !== '0 || bus_if.pipe_re !== '0 || bus_if.pipe_im !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: rdy/en/busy/done/und=%b%b%b%b%b cnt=%0d re=%0d, want all 0",
               bus_if.s_ready, bus_if.pipe_en, busy, frame_done, underrun, bus_if.pipe_cnt, bus_if.pipe_re);
    end
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
    tests++;
    if (frame_cnt !== 16'd0) begin
      fails++;
      $display("FAIL frame_cnt_reset: got %0d, want 0", frame_cnt);
    end
`endif
    #3 areset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (bus_if.s_ready !== 1'b0 || busy !== 1'b0 || bus_if.pipe_en !== 1'b0 || frame_done !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle c=%0d: rdy=%b busy=%b en=%b done=%b, want 0 0 0 0",
                 c, bus_if.s_ready, busy, bus_if.pipe_en, frame_done);
      end
    end
    bus_if.s_valid = 1'b0;
  endtask

  task automatic test_done_in_idle();
    bus_if.ret_en = 1'b1; bus_if.ret_cnt = NB'(LAST);
    tick(); bus_if.ret_en = 1'b0;
    tests++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || dut.outst_cnt_r !== 4'd0) begin
      fails++;
      $display("FAIL idle_done: frame_done=%b busy=%b outstanding=%0d, want 1 0 0",
               frame_done, busy, dut.outst_cnt_r);
    end
    tick();
    tests++;
    if (frame_done !== 1'b0) begin
      fails++;
      $display("FAIL idle_done_pulse: frame_done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_coincident();
    start = 1'b1; tick(); start = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k <= LAST; k++) begin
        start = (f == 0) && (k == LAST);
        bus_if.ret_en  = (f == 1) && (k == LAST);
        bus_if.ret_cnt = NB'(LAST);
        drive(k, 1'b1); tick();
      end
    end
    start = 1'b0; bus_if.ret_en = 1'b0; bus_if.s_valid = 1'b0;
    tests++;
    if (dut.outst_cnt_r !== 4'd1 || frame_done !== 1'b1 || busy !== 1'b1 || bus_if.s_ready !== 1'b0) begin
      fails++;
      $display("FAIL coincident: outstanding=%0d done=%b busy=%b rdy=%b, want 1 1 1 0",
               dut.outst_cnt_r, frame_done, busy, bus_if.s_ready);
    end
    tick();
    bus_if.ret_en = 1'b1;
    tick(); bus_if.ret_en = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || dut.outst_cnt_r !== 4'd0) begin
      fails++;
      $display("FAIL coincident_final: busy=%b outstanding=%0d, want 0 0", busy, dut.outst_cnt_r);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_reset_mid_load();
    test_done_in_idle();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter width, default 16, sample component width in bits.
REQ-002 SHALL have parameter N, default 9, log2 of FFT frame length (frame = 2^N samples).
REQ-003 SHALL have parameter CONT, default 0; 1 = free-running back-to-back frames without start.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port areset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request for one frame; sampled in IDLE and on the last LOAD cycle.
REQ-007 SHALL have ports s_valid input 1, s_ready output 1, s_re/s_im input width signed: sample stream.
REQ-008 SHALL have ports pipe_en output 1, pipe_cnt output N, pipe_re/pipe_im output width signed: first-stage drive.
REQ-009 SHALL have ports ret_en input 1, ret_cnt input N: en/cnt returned by the last pipeline stage.
REQ-010 SHALL have ports busy output 1, frame_done output 1, underrun output 1 (sticky).

Function
REQ-011 SHALL implement the states IDLE, LOAD and DRAIN; the reset state is IDLE.
REQ-012 IDLE->LOAD SHALL occur when start=1 or CONT=1; the same edge SHALL clear underrun.
REQ-013 In LOAD, s_ready SHALL be 1; in all other states s_ready SHALL be 0.
REQ-014 Each LOAD cycle SHALL register pipe_en=1, pipe_cnt=load counter, and pipe_re/pipe_im=s_re/s_im if s_valid else 0; latency from sample to pipe outputs is 1 cycle.
REQ-015 When LOAD runs with s_valid=0, the block SHALL insert a zero sample, SHALL NOT stall the counter, and SHALL set underrun to 1.
REQ-016 The load counter SHALL start at 0 and increment by 1 per LOAD cycle; at 2^N-1 it SHALL wrap to 0.
REQ-017 On the LOAD cycle with counter 2^N-1: if start=1 or CONT=1, the block SHALL stay in LOAD with no gap cycle; otherwise it SHALL go to DRAIN.
REQ-018 In IDLE and DRAIN, the registered pipe_en, pipe_cnt, pipe_re and pipe_im SHALL be 0.
REQ-019 The block SHALL keep a 4-bit outstanding-frame counter: +1 on each last LOAD cycle, -1 on each frame_done, unchanged when both occur; it SHALL saturate at 15 and at 0.
REQ-020 frame_done SHALL be a registered 1-cycle pulse, asserted the cycle after ret_en=1 and ret_cnt=2^N-1.
REQ-021 DRAIN->IDLE SHALL occur when the outstanding counter is 0 and no increment is pending; start in DRAIN SHALL be ignored.
REQ-022 busy SHALL be 1 whenever the state is not IDLE or the outstanding counter is non-zero.
REQ-023 A ret_en pulse arriving in IDLE SHALL still produce frame_done, and the counter SHALL stay at 0.

Reset
REQ-024 While areset=0, every output and all state SHALL be 0 and the state SHALL be IDLE, independent of clk.
REQ-025 A reset asserted mid-LOAD or mid-DRAIN SHALL abandon the frame; after release the block SHALL wait in IDLE (unless CONT=1) and SHALL NOT produce frame_done for the abandoned frame's count.

Configuration
REQ-026 Macro FFT_FRAME_CTRL_FRAME_CNT_EN, when defined, SHALL add output frame_cnt (16 bits) that counts frame_done pulses, wraps 65535->0 and resets to 0.
REQ-027 Without FFT_FRAME_CTRL_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 N=9, 1-cycle start, s_valid=1 throughout -> 512 pipe_en cycles with pipe_cnt 0..511, s_ready low after, DRAIN; ret_en/ret_cnt=511 -> frame_done pulse, busy=0 next cycle.
REQ-029 start held at cycle 511 of frame 1 -> pipe_cnt 511 followed directly by 0, outstanding counter reaches 2, two frame_done pulses, then IDLE.
REQ-030 s_valid=0 for load counts 100..102 -> pipe_re=pipe_im=0 on those samples, pipe_cnt unbroken, underrun=1 until next IDLE start.
REQ-031 areset low at pipe_cnt=300 -> all outputs 0 immediately, state IDLE after release, s_ready=0.
REQ-032 Last LOAD cycle coincident with a frame_done of the previous frame -> outstanding counter unchanged at 1.
REQ-033 With FFT_FRAME_CTRL_FRAME_CNT_EN defined, 3 frames -> frame_cnt=3; without it, the bench compiles with no frame_cnt port.
